// File: rtl/sobel_conv3x3_stream.sv
// Streaming 3x3 Sobel engine.
// Accepts one raster-order pixel per handshake and emits signed Gx/Gy plus a
// saturated |Gx|+|Gy| magnitude for every interior pixel of a frame.
// Two line RAMs feed a 3x3 window that also serves as pipeline stage 1;
// stage 2 is the output register set.
//
// Handshake rules (both ports): a transfer happens on a rising edge where
// valid and ready are both high. A producer holding valid high keeps its
// payload stable until the transfer. ready_o may depend combinationally on
// ready_i; valid_o never depends on valid_i.
module sobel_conv3x3_stream #(
  parameter int WIDTH_P    = 8,
  parameter int MAX_COLS_P = 640,
  localparam int CW        = $clog2(MAX_COLS_P + 1)
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [CW-1:0]          cols_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   sof_i,
  input  logic [WIDTH_P-1:0]     data_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   sof_o,
  output logic                   eol_o,
  output logic [2*WIDTH_P-1:0]   gx_o,
  output logic [2*WIDTH_P-1:0]   gy_o,
  output logic [WIDTH_P-1:0]     mag_o
);

  localparam int GW = 2 * WIDTH_P;

  // Position/frame state: col_q/row_q hold the position of the next pixel.
  logic [CW-1:0]      col_q;
  logic [CW-1:0]      row_q;
  logic [CW-1:0]      cols_q;
  logic               started_q;

  // Line RAMs (never reset) and the 3x3 window, win[row][col], row 0 = oldest line.
  logic [WIDTH_P-1:0] ram0 [MAX_COLS_P];
  logic [WIDTH_P-1:0] ram1 [MAX_COLS_P];
  logic [WIDTH_P-1:0] win  [3][3];

  // Stage 1 qualifiers for the window contents.
  logic               s1_v;
  logic               s1_sof;
  logic               s1_eol;

  logic               accept;
  logic               advance;
  logic [CW-1:0]      cols_clamped;
  logic [CW-1:0]      pos_col;
  logic [CW-1:0]      pos_row;
  logic [CW-1:0]      cols_eff;
  logic               started_eff;
  logic               last_col;
  logic               qualify;
  logic [WIDTH_P-1:0] top_px;
  logic [WIDTH_P-1:0] mid_px;

  logic [GW-1:0]      xr, xl, yb, yt;
  logic [GW-1:0]      gx_c, gy_c, ax, ay, msum;
  logic [WIDTH_P-1:0] mag_c;

  function automatic logic [GW-1:0] zx(input logic [WIDTH_P-1:0] v);
    return {{(GW - WIDTH_P){1'b0}}, v};
  endfunction

  // Stage 2 advances when it is empty or being consumed; stage 1 may then
  // refill, so a new pixel is taken whenever stage 1 is empty or advancing.
  assign advance = !valid_o || ready_i;
  assign ready_o = !s1_v || advance;
  assign accept  = valid_i && ready_o;

  // An sof pixel is itself at (0,0) with the new line length, so position
  // and length are resolved combinationally before use.
  assign cols_clamped = (cols_i > CW'(MAX_COLS_P)) ? CW'(MAX_COLS_P) : cols_i;
  assign pos_col      = sof_i ? '0 : col_q;
  assign pos_row      = sof_i ? '0 : row_q;
  assign cols_eff     = sof_i ? cols_clamped : cols_q;
  assign started_eff  = sof_i || started_q;

  // The MAX wrap keeps RAM addresses in range for degenerate lengths (0 or 1
  // after clamping never matches a short compare); such lines emit nothing.
  assign last_col = (pos_col == cols_eff - 1'b1) || (pos_col == CW'(MAX_COLS_P - 1));

  // Row >= 2 gating is what keeps stale RAM contents out of the results.
  assign qualify = started_eff && (cols_eff >= CW'(3)) &&
                   (pos_row >= CW'(2)) && (pos_col >= CW'(2));

  assign top_px = ram0[pos_col];
  assign mid_px = ram1[pos_col];

  // Position counters, line length latch and frame-seen flag.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      col_q     <= '0;
      row_q     <= '0;
      cols_q    <= '0;
      started_q <= 1'b0;
    end else if (accept) begin
      if (sof_i) begin
        cols_q    <= cols_clamped;
        started_q <= 1'b1;
      end
      if (last_col) begin
        col_q <= '0;
        row_q <= (pos_row == '1) ? pos_row : pos_row + 1'b1;
      end else begin
        col_q <= pos_col + 1'b1;
        row_q <= pos_row;
      end
    end
  end

  // Line buffer update, read-before-write: the old mid line moves up.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      ram0[pos_col] <= mid_px;
      ram1[pos_col] <= data_i;
    end
  end

  // Window shift and stage 1 valid/flags.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
      s1_v   <= 1'b0;
      s1_sof <= 1'b0;
      s1_eol <= 1'b0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= top_px;
      win[1][2] <= mid_px;
      win[2][2] <= data_i;
      s1_v      <= qualify;
      s1_sof    <= qualify && (pos_row == CW'(2)) && (pos_col == CW'(2));
      s1_eol    <= qualify && (pos_col == cols_eff - 1'b1);
    end else if (advance) begin
      s1_v <= 1'b0;
    end
  end

  // Sobel arithmetic on the stage 1 window, all operands zero-extended.
  always_comb begin
    xr   = zx(win[0][2]) + (zx(win[1][2]) << 1) + zx(win[2][2]);
    xl   = zx(win[0][0]) + (zx(win[1][0]) << 1) + zx(win[2][0]);
    yb   = zx(win[2][0]) + (zx(win[2][1]) << 1) + zx(win[2][2]);
    yt   = zx(win[0][0]) + (zx(win[0][1]) << 1) + zx(win[0][2]);
    gx_c = xr - xl;
    gy_c = yb - yt;
    ax   = gx_c[GW-1] ? (~gx_c + 1'b1) : gx_c;
    ay   = gy_c[GW-1] ? (~gy_c + 1'b1) : gy_c;
    // The sum never exceeds WIDTH_P+3 significant bits; any bit above
    // WIDTH_P-1 means saturation.
    msum  = ax + ay;
    mag_c = (|msum[GW-1:WIDTH_P]) ? '1 : msum[WIDTH_P-1:0];
  end

  // Stage 2 output registers; held while a result waits for ready_i.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_o <= 1'b0;
      sof_o   <= 1'b0;
      eol_o   <= 1'b0;
      gx_o    <= '0;
      gy_o    <= '0;
      mag_o   <= '0;
    end else if (advance) begin
      valid_o <= s1_v;
      sof_o   <= s1_v && s1_sof;
      eol_o   <= s1_v && s1_eol;
      if (s1_v) begin
        gx_o  <= gx_c;
        gy_o  <= gy_c;
        mag_o <= mag_c;
      end
    end
  end

endmodule

// File: tb/tb_sobel_conv3x3_stream.sv
// Testbench for sobel_conv3x3_stream: directed frame table, hand-written
// stall/reset sequences, and randomized frames against an image-array model.
module tb_sobel_conv3x3_stream;

  localparam int W    = 8;
  localparam int MAXC = 640;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int GW   = 2 * W;
  localparam int RW   = 2 + 2 * GW + W;
  localparam int MR   = 8;

  logic          clk_i;
  logic          rstn_i;
  logic [CW-1:0] cols_i;
  logic          valid_i;
  logic          ready_o;
  logic          sof_i;
  logic [W-1:0]  data_i;
  logic          valid_o;
  logic          ready_i;
  logic          sof_o;
  logic          eol_o;
  logic [GW-1:0] gx_o;
  logic [GW-1:0] gy_o;
  logic [W-1:0]  mag_o;

  sobel_conv3x3_stream #(.WIDTH_P(W), .MAX_COLS_P(MAXC)) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .cols_i  (cols_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .sof_i   (sof_i),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sof_o   (sof_o),
    .eol_o   (eol_o),
    .gx_o    (gx_o),
    .gy_o    (gy_o),
    .mag_o   (mag_o)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] cap_q[$];
  int            rdy_mode = 0;

  // Reference model: the current frame stored as a plain image array.
  int            img [MR][MAXC];
  int            m_row, m_col, m_cols;
  bit            m_started = 0;

  typedef struct {
    int          rows;
    int          cols;
    int          kind;
    int          n;
    logic [15:0] gx0;
    logic [15:0] gy0;
    logic [7:0]  mag0;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pix(input int kind, input int r, input int c);
    case (kind)
      0:       return W'(10 * c);
      1:       return W'(10 * r);
      2:       return W'(200 - 10 * c);
      3:       return (c < 2) ? W'(0) : W'(255);
      4:       return W'(50);
      6:       return W'(r * 16 + c * 3);
      default: return W'($urandom_range(0, 255));
    endcase
  endfunction

  // Sobel at centre (R-1,C-1) from the stored image.
  task automatic model_result(input int rr, input int cc);
    int gx, gy, ax, ay, mg;
    int k [3];
    k = '{1, 2, 1};
    gx = 0;
    gy = 0;
    for (int i = 0; i < 3; i++) begin
      gx += k[i] * (img[rr - 2 + i][cc] - img[rr - 2 + i][cc - 2]);
      gy += k[i] * (img[rr][cc - 2 + i] - img[rr - 2][cc - 2 + i]);
    end
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    mg = (ax + ay > 255) ? 255 : ax + ay;
    exp_q.push_back({(rr == 2 && cc == 2), (cc == m_cols - 1),
                     GW'(gx), GW'(gy), W'(mg)});
  endtask

  task automatic model_accept(input logic [W-1:0] d, input bit sof, input int cols);
    if (sof) begin
      m_row     = 0;
      m_col     = 0;
      m_cols    = (cols > MAXC) ? MAXC : cols;
      m_started = 1;
    end
    if (m_started) begin
      if (m_row < MR && m_col < MAXC) img[m_row][m_col] = int'(d);
      if (m_cols >= 3 && m_row >= 2 && m_row < MR && m_col >= 2 && m_col < m_cols)
        model_result(m_row, m_col);
      if (m_col == m_cols - 1) begin
        m_col = 0;
        m_row++;
      end else begin
        m_col++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_pixel(input logic [W-1:0] d, input bit sof, input int cols);
    int  n    = 0;
    bit  done = 0;
    valid_i = 1'b1;
    data_i  = d;
    sof_i   = sof;
    cols_i  = CW'(cols);
    while (!done) begin
      @(negedge clk_i);
      if (ready_o) done = 1;
      @(posedge clk_i);
      #1;
      if (!done) begin
        n++;
        if (n > 300) begin
          chk("accept_timeout", 64'(ready_o), 64'd1);
          valid_i = 1'b0;
          sof_i   = 1'b0;
          return;
        end
      end
    end
    model_accept(d, sof, cols);
    valid_i = 1'b0;
    sof_i   = 1'b0;
  endtask

  task automatic send_frame(input int rows, input int cols, input int kind,
                            input int limit, input bit gaps);
    int cnt = 0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        if (cnt >= limit) return;
        send_pixel(pix(kind, r, c), (r == 0 && c == 0), cols);
        cnt++;
        if (gaps && $urandom_range(0, 3) == 0) begin
          @(posedge clk_i);
          #1;
        end
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk_i);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    repeat (6) @(posedge clk_i);
    #1;
  endtask

  task automatic rdy_driver();
    forever begin
      @(posedge clk_i);
      #1;
      case (rdy_mode)
        1:       ready_i = ($urandom_range(0, 3) != 0);
        2:       ready_i = 1'b0;
        default: ready_i = 1'b1;
      endcase
    end
  endtask

  // Compares every transferred result with the model and checks hold stability.
  task automatic monitor();
    logic [RW-1:0] cur, held, e;
    bit            hv = 0;
    forever begin
      @(negedge clk_i);
      if (!rstn_i) begin
        hv = 0;
      end else begin
        cur = {sof_o, eol_o, gx_o, gy_o, mag_o};
        if (hv) chk("hold_stable", 64'({valid_o, cur}), 64'({1'b1, held}));
        if (valid_o && ready_i) begin
          cap_q.push_back(cur);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got 0x%0h expected none (t=%0t)", cur, $time);
          end else begin
            e = exp_q.pop_front();
            chk("result", 64'(cur), 64'(e));
          end
          hv = 0;
        end else if (valid_o) begin
          hv   = 1;
          held = cur;
        end else begin
          hv = 0;
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid_o"}, 64'(valid_o), 64'd0);
    chk({tag, "_sof_eol"}, 64'({sof_o, eol_o}), 64'd0);
    chk({tag, "_gx_gy"},   64'({gx_o, gy_o}), 64'd0);
    chk({tag, "_mag"},     64'(mag_o), 64'd0);
    chk({tag, "_ready_o"}, 64'(ready_o), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t tbl [6];
    int   n;

    rstn_i  = 1'b0;
    valid_i = 1'b0;
    sof_i   = 1'b0;
    data_i  = '0;
    cols_i  = '0;
    ready_i = 1'b1;

    tbl[0] = '{4, 5, 0, 6, 16'd80,    16'd0,  8'd80};
    tbl[1] = '{4, 5, 1, 6, 16'd0,     16'd80, 8'd80};
    tbl[2] = '{4, 5, 2, 6, 16'hFFB0,  16'd0,  8'd80};
    tbl[3] = '{3, 5, 3, 3, 16'd1020,  16'd0,  8'd255};
    tbl[4] = '{4, 5, 4, 6, 16'd0,     16'd0,  8'd0};
    tbl[5] = '{4, 2, 4, 0, 16'd0,     16'd0,  8'd0};

    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    @(negedge clk_i);
    rstn_i = 1'b1;

    fork
      monitor();
      rdy_driver();
    join_none

    @(posedge clk_i);
    #1;

    // Pixels before any sof produce nothing.
    for (int i = 0; i < 12; i++) send_pixel(pix(5, 0, 0), 1'b0, 5);
    drain();

    // Directed frame table.
    for (int t = 0; t < 6; t++) begin
      cap_q.delete();
      send_frame(tbl[t].rows, tbl[t].cols, tbl[t].kind, 1 << 20, 1'b0);
      drain();
      chk($sformatf("tbl%0d_count", t), 64'(cap_q.size()), 64'(tbl[t].n));
      if (cap_q.size() > 0 && tbl[t].n > 0) begin
        chk($sformatf("tbl%0d_gx0", t),  64'(cap_q[0][RW-3 -: GW]), 64'(tbl[t].gx0));
        chk($sformatf("tbl%0d_gy0", t),  64'(cap_q[0][RW-3-GW -: GW]), 64'(tbl[t].gy0));
        chk($sformatf("tbl%0d_mag0", t), 64'(cap_q[0][W-1:0]), 64'(tbl[t].mag0));
        for (int i = 0; i < cap_q.size(); i++) begin
          chk($sformatf("tbl%0d_sof%0d", t, i), 64'(cap_q[i][RW-1]), 64'(i == 0));
          chk($sformatf("tbl%0d_eol%0d", t, i), 64'(cap_q[i][RW-2]),
              64'((i % (tbl[t].cols - 2)) == tbl[t].cols - 3));
        end
      end
    end

    // Back-pressure: ready_i low for 3 cycles in the middle of a line.
    cap_q.delete();
    fork
      send_frame(4, 10, 6, 1 << 20, 1'b0);
      begin
        n = 0;
        while (cap_q.size() < 3 && n < 500) begin
          @(negedge clk_i);
          n++;
        end
        chk("stall_start_seen", 64'(cap_q.size() >= 3), 64'd1);
        rdy_mode = 2;
        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("stall_ready_o_low", 64'({ready_i, ready_o}), 64'd0);
        @(negedge clk_i);
        chk("stall_ready_o_low2", 64'({ready_i, ready_o}), 64'd0);
        rdy_mode = 0;
      end
    join
    drain();
    chk("stall_count", 64'(cap_q.size()), 64'd16);

    // Two frames back to back with different line lengths.
    cap_q.delete();
    send_frame(4, 4, 5, 1 << 20, 1'b0);
    drain();
    chk("frame_c4_count", 64'(cap_q.size()), 64'd4);
    cap_q.delete();
    send_frame(4, 6, 5, 1 << 20, 1'b0);
    drain();
    chk("frame_c6_count", 64'(cap_q.size()), 64'd8);

    // Randomized frames, random gaps, random back-pressure, one abort.
    rdy_mode = 1;
    for (int f = 0; f < 8; f++) begin
      send_frame($urandom_range(1, 6), $urandom_range(1, 12), 5, 1 << 20, 1'b1);
    end
    send_frame(5, 7, 5, 20, 1'b1);
    send_frame(4, 5, 5, 1 << 20, 1'b1);
    drain();
    rdy_mode = 0;
    repeat (2) @(posedge clk_i);
    #1;

    // Reset in the middle of a frame with a result in flight.
    send_frame(4, 6, 5, 17, 1'b0);
    chk("inflight_before_reset", 64'(valid_o), 64'd1);
    #1;
    rstn_i = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    m_started = 0;
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 8; i++) send_pixel(pix(5, 0, 0), 1'b0, 5);
    drain();
    cap_q.delete();
    send_frame(4, 5, 4, 1 << 20, 1'b0);
    drain();
    chk("after_reset_count", 64'(cap_q.size()), 64'd6);
    for (int i = 0; i < cap_q.size(); i++)
      chk($sformatf("after_reset_zero%0d", i), 64'(cap_q[i][RW-3:0]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
